// File: rtl/mem_io_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mem_io_pkg
// Description : Shared I/O offsets, decode select and UART state encodings
//               for the memory/I-O bridge.
// Revision    : 1.0 - initial release
//==============================================================================
package mem_io_pkg;

    localparam logic [7:0] OFF_GPIO      = 8'h00;
    localparam logic [7:0] OFF_BTN       = 8'h01;
    localparam logic [7:0] OFF_UART_DATA = 8'h02;
    localparam logic [7:0] OFF_UART_STAT = 8'h03;
    localparam logic [7:0] OFF_TICK      = 8'h04;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } sel_e;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_io_bridge_if.sv
`default_nettype none
//==============================================================================
// Module      : mem_io_bridge_if
// Description : Core-to-memory bus: address, write data/strobe, read data.
// Revision    : 1.0 - initial release
//==============================================================================
interface mem_io_bridge_if;

    logic [23:0] core_to_mem_address;
    logic [15:0] core_to_mem_data;
    logic        core_to_mem_write_enable;
    logic [15:0] mem_to_core_data;

    modport master (
        output core_to_mem_address,
        output core_to_mem_data,
        output core_to_mem_write_enable,
        input  mem_to_core_data
    );

    modport slave (
        input  core_to_mem_address,
        input  core_to_mem_data,
        input  core_to_mem_write_enable,
        output mem_to_core_data
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx
// Description : Byte FIFO feeding an 8N1 serializer (LSB first).
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx
    import mem_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 434
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       push,
    input  wire logic [7:0] data,
    output logic            full,
    output logic            empty,
    output logic            busy,
    output logic            tx
);

    localparam int              c_aw        = $clog2(FIFO_DEPTH);
    localparam int              c_cw        = $clog2(BAUD_DIV + 1);
    localparam logic [c_cw-1:0] c_baud_last = c_cw'(BAUD_DIV - 1);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw:0]   r_wptr;
    logic [c_aw:0]   r_rptr;
    logic [1:0]      r_state;
    logic [c_cw-1:0] r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic            w_push_ok;
    logic            w_pop;
    logic            w_baud_done;
    logic [2:0]      w_next_idx;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty       = (r_wptr == r_rptr);
    assign full        = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                         (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign busy        = (r_state != UART_IDLE);
    assign tx          = r_tx;
    assign w_push_ok   = push && !full;
    assign w_pop       = (r_state == UART_IDLE) && !empty;
    assign w_baud_done = (r_baud_cnt == c_baud_last);
    assign w_next_idx  = r_bit_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[c_aw-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (c_aw+1)'(1);
            if (w_pop)     r_rptr <= r_rptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= UART_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                UART_IDLE: begin
                    r_tx <= 1'b1;
                    if (!empty) begin
                        r_shift    <= r_mem[r_rptr[c_aw-1:0]];
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= UART_START;
                    end
                end
                UART_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= UART_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cw'(1);
                    end
                end
                UART_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= UART_STOP;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cw'(1);
                    end
                end
                UART_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= UART_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cw'(1);
                    end
                end
                default: r_state <= UART_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
//==============================================================================
// Module      : mem_io_bridge
// Description : Routes core accesses to block RAM or the I/O window (GPIO,
//               buttons, tick counter, UART TX). Optional macro:
//               BTN_DEBOUNCE_EN enables per-button debounce counters.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int          RAM_ADDR_W      = 14,
    parameter logic [23:0] IO_BASE         = 24'hFFFF00,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          BAUD_DIV        = 434,
    parameter int          TICK_DIV        = 50000,
    parameter int          DEBOUNCE_CYCLES = 65536
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    mem_io_bridge_if.slave             bus,
    output logic [RAM_ADDR_W-1:0]      ram_addr,
    output logic [15:0]                ram_wdata,
    output logic                       ram_we,
    input  wire logic [15:0]           ram_rdata,
    input  wire logic [3:0]            btn_in,
    output logic [15:0]                gpio_out,
    output logic                       uart_tx
);

`ifdef BTN_DEBOUNCE_EN
    localparam bit c_debounce = 1'b1;
`else
    localparam bit c_debounce = 1'b0;
`endif

    localparam int              c_tw        = $clog2(TICK_DIV + 1);
    localparam logic [c_tw-1:0] c_tick_last = c_tw'(TICK_DIV - 1);

    sel_e            w_sel;
    sel_e            r_sel;
    logic [7:0]      w_off;
    logic            w_io_we;
    logic            w_wr_gpio, w_wr_btn, w_wr_udata, w_wr_ustat, w_wr_tick;
    logic [15:0]     w_io_rdata;
    logic [15:0]     r_io_rdata;
    logic [15:0]     r_gpio;
    logic [3:0]      r_sync1, r_sync2, r_level_d, r_sticky;
    logic [3:0]      w_level, w_rise, w_clr;
    logic            r_ovf;
    logic            w_full, w_empty, w_busy;
    logic [15:0]     r_tick;
    logic [c_tw-1:0] r_tick_pre;

    assign w_off = bus.core_to_mem_address[7:0];

    always_comb begin
        w_sel = SEL_NONE;
        if (bus.core_to_mem_address[23:RAM_ADDR_W] == '0) begin
            w_sel = SEL_RAM;
        end else if (bus.core_to_mem_address[23:8] == IO_BASE[23:8]) begin
            w_sel = SEL_IO;
        end
    end

    assign ram_addr   = bus.core_to_mem_address[RAM_ADDR_W-1:0];
    assign ram_wdata  = bus.core_to_mem_data;
    assign ram_we     = bus.core_to_mem_write_enable && (w_sel == SEL_RAM);

    assign w_io_we    = bus.core_to_mem_write_enable && (w_sel == SEL_IO);
    assign w_wr_gpio  = w_io_we && (w_off == OFF_GPIO);
    assign w_wr_btn   = w_io_we && (w_off == OFF_BTN);
    assign w_wr_udata = w_io_we && (w_off == OFF_UART_DATA);
    assign w_wr_ustat = w_io_we && (w_off == OFF_UART_STAT);
    assign w_wr_tick  = w_io_we && (w_off == OFF_TICK);

    // Reads must never change state: the core parks on address 0 when idle.
    always_comb begin
        w_io_rdata = '0;
        case (w_off)
            OFF_GPIO:      w_io_rdata = r_gpio;
            OFF_BTN:       w_io_rdata = {8'h00, r_sticky, w_level};
            OFF_UART_STAT: w_io_rdata = {12'h000, r_ovf, w_busy, w_empty, w_full};
            OFF_TICK:      w_io_rdata = r_tick;
            default:       w_io_rdata = '0;
        endcase
    end

    assign bus.mem_to_core_data = (r_sel == SEL_RAM) ? ram_rdata  :
                                  (r_sel == SEL_IO)  ? r_io_rdata : 16'h0000;
    assign gpio_out = r_gpio;

    generate
        if (c_debounce) begin : g_debounce
            localparam int              c_dw      = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [c_dw-1:0] c_db_last = c_dw'(DEBOUNCE_CYCLES - 1);
            for (genvar i = 0; i < 4; i++) begin : g_bit
                logic [c_dw-1:0] r_cnt;
                logic            r_lvl;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cnt <= '0;
                        r_lvl <= 1'b0;
                    end else if (r_sync2[i] == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_cnt <= '0;
                        r_lvl <= r_sync2[i];
                    end else begin
                        r_cnt <= r_cnt + c_dw'(1);
                    end
                end
                assign w_level[i] = r_lvl;
            end
        end else begin : g_raw_level
            assign w_level = r_sync2;
        end
    endgenerate

    assign w_rise = w_level & ~r_level_d;
    assign w_clr  = w_wr_btn ? bus.core_to_mem_data[7:4] : 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= SEL_NONE;
            r_io_rdata <= '0;
            r_gpio     <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_level_d  <= '0;
            r_sticky   <= '0;
            r_ovf      <= 1'b0;
            r_tick     <= '0;
            r_tick_pre <= '0;
        end else begin
            r_sel      <= w_sel;
            r_io_rdata <= w_io_rdata;
            r_sync1    <= btn_in;
            r_sync2    <= r_sync1;
            r_level_d  <= w_level;
            // A fresh press outranks a simultaneous clear.
            r_sticky   <= (r_sticky & ~w_clr) | w_rise;
            r_ovf      <= (r_ovf & ~(w_wr_ustat && bus.core_to_mem_data[3])) |
                          (w_wr_udata && w_full);
            if (w_wr_gpio) begin
                r_gpio <= bus.core_to_mem_data;
            end
            if (w_wr_tick) begin
                r_tick     <= '0;
                r_tick_pre <= '0;
            end else if (r_tick_pre == c_tick_last) begin
                r_tick_pre <= '0;
                r_tick     <= r_tick + 16'd1;
            end else begin
                r_tick_pre <= r_tick_pre + c_tw'(1);
            end
        end
    end

    uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_DIV   (BAUD_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_udata),
        .data  (bus.core_to_mem_data[7:0]),
        .full  (w_full),
        .empty (w_empty),
        .busy  (w_busy),
        .tx    (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_io_bridge
// Description : Scoreboard bench for mem_io_bridge: read-data and serial-byte
//               queues checked by independent monitors.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mem_io_bridge;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [3:0]  btn_in;
    logic [15:0] gpio_out;
    logic        uart_tx;

    mem_io_bridge_if bus();

    mem_io_bridge #(
        .RAM_ADDR_W      (14),
        .IO_BASE         (24'hFFFF00),
        .FIFO_DEPTH      (8),
        .BAUD_DIV        (4),
        .TICK_DIV        (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .btn_in    (btn_in),
        .gpio_out  (gpio_out),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    // Block RAM with registered read (read-before-write).
    logic [15:0] ram_mem [16384];
    initial begin
        for (int i = 0; i < 16384; i++) ram_mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) if (ram_we) we_cnt++;

    // Read scoreboard
    typedef struct {
        logic [15:0] data;
        string       name;
    } rd_exp_t;
    rd_exp_t rd_q[$];
    logic    rd_flag = 1'b0;
    logic    rd_d    = 1'b0;

    always @(posedge clk) rd_d = rd_flag;

    always @(negedge clk) begin
        if (rd_d) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus.mem_to_core_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check(e.name, {16'h0, bus.mem_to_core_data}, {16'h0, e.data});
            end
        end
    end

    // Serial scoreboard: 4 clocks per bit, sampled on falling edges.
    logic [7:0] ux_q[$];
    logic       mon_en = 1'b0;

    initial begin : uart_mon
        logic       prev;
        logic [7:0] got;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !uart_tx) begin
                repeat (3) @(negedge clk);
                check("uart_start_len", {31'h0, uart_tx}, 32'h0);
                for (int k = 0; k < 8; k++) begin
                    repeat ((k == 0) ? 3 : 4) @(negedge clk);
                    got[k] = uart_tx;
                end
                repeat (2) @(negedge clk);
                check("uart_stop_early", {31'h0, uart_tx}, 32'h1);
                repeat (3) @(negedge clk);
                check("uart_stop_late", {31'h0, uart_tx}, 32'h1);
                if (ux_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL uart_byte: got 0x%0h, expected no frame", got);
                end else begin
                    check("uart_byte", {24'h0, got}, {24'h0, ux_q.pop_front()});
                end
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        bus.core_to_mem_address      = a;
        bus.core_to_mem_data         = d;
        bus.core_to_mem_write_enable = 1'b1;
        cyc();
        bus.core_to_mem_write_enable = 1'b0;
        bus.core_to_mem_address      = 24'h0;
    endtask

    task automatic rd(input logic [23:0] a, input logic [15:0] exp, input string name);
        rd_exp_t e;
        e.data = exp;
        e.name = name;
        rd_q.push_back(e);
        bus.core_to_mem_address = a;
        rd_flag = 1'b1;
        cyc();
        rd_flag = 1'b0;
        bus.core_to_mem_address = 24'h0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        bus.core_to_mem_address      = 24'h0;
        bus.core_to_mem_data         = 16'h0;
        bus.core_to_mem_write_enable = 1'b0;
        btn_in = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", {16'h0, bus.mem_to_core_data}, 32'h0);
        check("rst_gpio", {16'h0, gpio_out}, 32'h0);
        check("rst_tx", {31'h0, uart_tx}, 32'h1);
        rst_n = 1'b1;
        cyc();
        cyc();
        rd(24'hFFFF03, 16'h0002, "rst_status");
        rd(24'hFFFF01, 16'h0000, "rst_btn");

        // RAM write/read at program start
        we_cnt = 0;
        wr(24'h003C8C, 16'h1234);
        check("ram_we_pulse", we_cnt, 32'd1);
        rd(24'h003C8C, 16'h1234, "ram_rd");

        // GPIO and unmapped region
        wr(24'hFFFF00, 16'hA5A5);
        check("gpio_out", {16'h0, gpio_out}, 32'h0000A5A5);
        rd(24'hFFFF00, 16'hA5A5, "gpio_rd");
        we_cnt = 0;
        wr(24'h400000, 16'hBEEF);
        check("none_we", we_cnt, 32'd0);
        rd(24'h400000, 16'h0000, "none_rd");
        rd(24'hFFFF10, 16'h0000, "unmapped_rd");
        rd(24'h003C8C, 16'h1234, "ram_rd2");

        // Tick: restart, then read across the first increment
        wr(24'hFFFF04, 16'hFFFF);
        repeat (9) cyc();
        rd(24'hFFFF04, 16'h0000, "tick_before");
        rd(24'hFFFF04, 16'h0001, "tick_after");

        // Single UART byte
        mon_en = 1'b1;
        ux_q.push_back(8'h55);
        wr(24'hFFFF02, 16'h0055);
        rd(24'hFFFF03, 16'h0000, "stat_queued");
        rd(24'hFFFF03, 16'h0006, "stat_busy0");
        for (int i = 0; i < 4; i++) begin
            repeat (8) cyc();
            rd(24'hFFFF03, 16'h0006, "stat_busy");
        end
        repeat (5) cyc();
        rd(24'hFFFF03, 16'h0002, "stat_idle");

        // FIFO burst with overflow
        for (int i = 0; i < 9; i++) begin
            ux_q.push_back(8'(i));
            wr(24'hFFFF02, 16'(i));
        end
        rd(24'hFFFF03, 16'h0005, "stat_full");
        wr(24'hFFFF02, 16'h0009);
        rd(24'hFFFF03, 16'h000D, "stat_ovf");
        wr(24'hFFFF03, 16'h0008);
        rd(24'hFFFF03, 16'h0005, "stat_ovf_clr");
        for (int i = 0; i < 800 && ux_q.size() != 0; i++) cyc();
        check("uart_drain", ux_q.size(), 32'd0);
        repeat (60) cyc();
        rd(24'hFFFF03, 16'h0002, "stat_drained");

        // Buttons
        btn_in = 4'b0010;
        repeat (5) cyc();
        rd(24'hFFFF01, 16'h0022, "btn_held");
        btn_in = 4'b0000;
        repeat (5) cyc();
        rd(24'hFFFF01, 16'h0020, "btn_released");
        wr(24'hFFFF01, 16'h0020);
        rd(24'hFFFF01, 16'h0000, "btn_cleared");
        btn_in = 4'b0010;
        cyc();
        cyc();
        wr(24'hFFFF01, 16'h00F0);
        rd(24'hFFFF01, 16'h0022, "btn_clr_vs_set");
        btn_in = 4'b0000;
        repeat (4) cyc();
        wr(24'hFFFF01, 16'h00F0);
        rd(24'hFFFF01, 16'h0000, "btn_final");

        // Asynchronous reset in the middle of a data bit
        mon_en = 1'b0;
        wr(24'hFFFF00, 16'h5A5A);
        wr(24'hFFFF02, 16'h0000);
        wr(24'hFFFF02, 16'h00FF);
        bus.core_to_mem_address = 24'hFFFF00;
        repeat (9) cyc();
        check("pre_rst_tx", {31'h0, uart_tx}, 32'h0);
        check("pre_rst_rdata", {16'h0, bus.mem_to_core_data}, 32'h00005A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'h0, uart_tx}, 32'h1);
        check("async_rst_gpio", {16'h0, gpio_out}, 32'h0);
        check("async_rst_rdata", {16'h0, bus.mem_to_core_data}, 32'h0);
        cyc();
        rst_n = 1'b1;
        bus.core_to_mem_address = 24'h0;
        cyc();
        rd(24'hFFFF03, 16'h0002, "post_rst_status");
        rd(24'hFFFF00, 16'h0000, "post_rst_gpio");
        rd(24'hFFFF01, 16'h0000, "post_rst_btn");

        repeat (3) cyc();
        check("rd_queue_empty", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Memory-side neighbour of the CPU core. Takes the core's 24-bit address, 16-bit write data and write-enable, and returns read data exactly one cycle after the address is presented.
- Routes each access to either a single-port block RAM or a small memory-mapped I/O window.
- The I/O window provides GPIO, button status with sticky press flags, a tick counter, and a FIFO-buffered 8N1 UART transmitter.

Parameters:
RAM_ADDR_W, 14, word-address width of block RAM (16384 words; covers the program start at 0x003C8C)
IO_BASE, 24'hFFFF00, base of the 256-word I/O window (low 8 bits are the register offset)
FIFO_DEPTH, 8, UART TX FIFO entries (power of two)
BAUD_DIV, 434, clk cycles per UART bit
TICK_DIV, 50000, clk cycles per tick-counter increment
DEBOUNCE_CYCLES, 65536, stable cycles required before a button level is accepted (used only with BTN_DEBOUNCE_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
core_to_mem_address  in  24  word address from core
core_to_mem_data  in  16  write data from core
core_to_mem_write_enable  in  1  write strobe, committed on the same rising edge
mem_to_core_data  out  16  read data, valid the cycle after the address
ram_addr  out  RAM_ADDR_W  block RAM address (combinational pass-through)
ram_wdata  out  16  block RAM write data
ram_we  out  1  block RAM write enable; only asserted when the address decodes to RAM
ram_rdata  in  16  block RAM registered read data (1-cycle latency)
btn_in  in  4  raw asynchronous push buttons
gpio_out  out  16  GPIO output register
uart_tx  out  1  serial output, idles high

Behaviour:
- Decode (combinational):
  - RAM when address < 2^RAM_ADDR_W.
  - IO when address[23:8] == IO_BASE[23:8].
  - NONE otherwise.
  - NONE accesses read 0 and ignore writes.
- Read path:
  - On every edge, register sel_q (RAM/IO/NONE) and io_rdata_q.
  - mem_to_core_data = ram_rdata when sel_q==RAM, io_rdata_q when sel_q==IO, 0 otherwise.
  - Reads are side-effect free. This is mandatory: the core drives address 0 whenever it is idle.
- I/O map by offset (unlisted offsets read 0, writes ignored):
  - 0x00 GPIO: RW. gpio_out updates on the write edge.
  - 0x01 BTN:
    - Read {8'h0, sticky[3:0], level[3:0]}.
    - Writing 1 to bits [7:4] clears the matching sticky bit.
  - 0x02 UART_DATA: write pushes data[7:0] into the FIFO. A push when full is dropped and sets ovf.
  - 0x03 UART_STATUS:
    - Read {12'h0, ovf, busy, empty, full}.
    - Writing bit3=1 clears ovf.
  - 0x04 TICK:
    - 16-bit counter; increments every TICK_DIV cycles and wraps 0xFFFF->0.
    - Any write resets it to 0, and its prescaler also restarts.
- Buttons:
  - Each bit goes through a 2-flop synchronizer, giving level.
  - A rising edge of level sets sticky.
  - If a clear and a new edge hit the same bit in the same cycle, set wins.
- UART FIFO:
  - Circular buffer with read/write pointers, each one bit wider than the index.
  - full/empty are derived from the pointers.
  - Push and pop in the same cycle is legal when not full.
  - Push when full is dropped even if a pop occurs that cycle.
- UART FSM:
  - IDLE: if FIFO not empty, pop and load the shifter, go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA.
  - DATA: 8 bits LSB-first, BAUD_DIV cycles each; a 3-bit counter selects the bit.
  - STOP: uart_tx=1 for BAUD_DIV cycles, then IDLE.
  - busy=1 in every state except IDLE.
  - Back-to-back bytes: the next start bit immediately follows STOP; there are no extra idle cycles beyond the one IDLE cycle.
- Reset (any time, including mid-frame):
  - mem_to_core_data=0 (sel_q=NONE), gpio_out=0, uart_tx=1, FSM=IDLE.
  - FIFO empty; ovf, sticky, synchronizers and tick all 0.
  - ram_we is combinational and equals 0 whenever core write-enable is 0.

Optional Feature:
BTN_DEBOUNCE_EN:
- Defined: each synchronized bit feeds a counter. level only changes after the input differs from level for DEBOUNCE_CYCLES consecutive cycles; the counter resets on any bounce.
- Undefined: level is the synchronizer output directly, with no counters instantiated.

Decomposition:
- Package mem_io_pkg holds:
  - IO register offsets (OFF_GPIO, OFF_BTN, OFF_UART_DATA, OFF_UART_STAT, OFF_TICK).
  - The decode select enum (SEL_NONE/RAM/IO).
  - The UART state encoding (UART_IDLE/START/DATA/STOP).
- One sub-module: uart_tx, containing the FIFO plus serializer.
  - Inputs: push and data.
  - Outputs: full, empty, busy, tx.

Test Plan:
- Write 0x1234 to 0x003C8C, then present 0x003C8C -> mem_to_core_data=0x1234 on the following cycle; ram_we pulsed exactly 1 cycle.
- Write 0xA5A5 to 0xFFFF00 -> gpio_out=0xA5A5 next cycle, readback 0xA5A5; write to 0x400000 -> ram_we stays 0, read returns 0.
- BAUD_DIV=4, write 0x55 to 0xFFFF02 -> uart_tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; status busy=1 throughout, then 0x0002.
- BAUD_DIV=4, 10 consecutive UART_DATA writes 0x00..0x09:
  - Status reads full then ovf=1.
  - Serial stream is 0x00..0x08; 0x09 is dropped.
  - Writing 0x0008 to STATUS clears ovf.
- Pulse btn_in[1] -> BTN reads 0x0022 while held, 0x0020 after release; write 0x0020 -> 0x0000; clear coincident with a new edge -> sticky stays 1.
- Assert rst_n low mid-DATA-bit -> uart_tx=1, status=0x0002, gpio_out=0, mem_to_core_data=0 immediately (asynchronous).
